// File: rtl/maxnet_ctrl_if.sv
// ---------------------------------------------------------------------------
// maxnet_ctrl_if
// Bundles the controller's host request, datapath status inputs, datapath
// control outputs and run status into one interface.
//
// Signals:
//   go          host run request (into controller)
//   plu_done    AND of the four PLU done flags (into controller)
//   finish      output-checker valid, single winner found (into controller)
//   rst_plu     PLU internal reset
//   eps_reg_we  epsilon register write enable
//   we_a_reg    activation register write enable
//   we_prim     original-activation register write enable
//   mux_sel     activation source: 0 = init inputs, 1 = PLU outputs
//   start       PLU start
//   busy        run in progress
//   done        run finished, status valid
//   timeout     while done: 1 = aborted, 0 = converged
//   iter_count  completed write-backs in the current or last run
//
// Modports:
//   master  the controller side (drives the control/status outputs)
//   slave   the host/datapath side
// ---------------------------------------------------------------------------
interface maxnet_ctrl_if #(
    parameter int ITER_W = 7
);
    logic              go;
    logic              plu_done;
    logic              finish;
    logic              rst_plu;
    logic              eps_reg_we;
    logic              we_a_reg;
    logic              we_prim;
    logic              mux_sel;
    logic              start;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;

    modport master (
        input  go,
        input  plu_done,
        input  finish,
        output rst_plu,
        output eps_reg_we,
        output we_a_reg,
        output we_prim,
        output mux_sel,
        output start,
        output busy,
        output done,
        output timeout,
        output iter_count
    );

    modport slave (
        output go,
        output plu_done,
        output finish,
        input  rst_plu,
        input  eps_reg_we,
        input  we_a_reg,
        input  we_prim,
        input  mux_sel,
        input  start,
        input  busy,
        input  done,
        input  timeout,
        input  iter_count
    );
endinterface

// File: rtl/maxnet_ctrl.sv
// ---------------------------------------------------------------------------
// maxnet_ctrl
// Sequencing controller for the MaxNet datapath. On a host run request it
// loads the initial activations and epsilon, then loops CLR -> COMPUTE ->
// UPDATE -> CHECK, firing the four PLUs and writing their results back,
// until the output checker reports a single winner. Run time is bounded by
// an iteration cap and a per-iteration PLU watchdog.
//
// Parameters:
//   MAX_ITER  iteration cap (write-backs without finish before abort)
//   ITER_W    width of iter_count, 2**ITER_W must exceed MAX_ITER
//   WDOG      maximum cycles spent in COMPUTE waiting for plu_done
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   maxnet_ctrl_if.master: go/plu_done/finish in, datapath control
//         and run status out
// ---------------------------------------------------------------------------
module maxnet_ctrl #(
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7,
    parameter int WDOG     = 32
) (
    input  logic            clk,
    input  logic            rst,
    maxnet_ctrl_if.master   bus
);

    // The watchdog only needs to reach WDOG-1 before COMPUTE is forced out,
    // but one extra bit keeps the increment in range on the final cycle.
    localparam int                WDOG_W    = $clog2(WDOG + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG - 1);
    localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_COMPUTE,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [ITER_W-1:0] r_iterCount;
    logic              r_timeout;
    logic [WDOG_W-1:0] r_wdog;

    logic              w_wdogExpire;
    logic              w_capHit;
    logic              w_iterSat;

    logic              w_rstPlu;
    logic              w_epsRegWe;
    logic              w_weAReg;
    logic              w_wePrim;
    logic              w_muxSel;
    logic              w_start;
    logic              w_busy;
    logic              w_done;

    // Abort conditions, evaluated against the registered counters so the
    // decision taken in COMPUTE/CHECK reflects the cycle just completed.
    assign w_wdogExpire = (r_wdog == WDOG_LAST);
    assign w_capHit     = (r_iterCount == ITER_CAP);
    assign w_iterSat    = (r_iterCount == {ITER_W{1'b1}});

    // State register. Reset wins over every other input, including a run
    // in progress, so no write-enable can leak out after a mid-run reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. plu_done beats the watchdog in COMPUTE and finish
    // beats the iteration cap in CHECK, so a result that arrives on the
    // last permitted cycle still counts as a success.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                w_nextState = S_CLR;
            end
            S_CLR: begin
                w_nextState = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (bus.plu_done) begin
                    w_nextState = S_UPDATE;
                end else if (w_wdogExpire) begin
                    w_nextState = S_DONE;
                end
            end
            S_UPDATE: begin
                w_nextState = S_CHECK;
            end
            S_CHECK: begin
                if (bus.finish || w_capHit) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_CLR;
                end
            end
            S_DONE: begin
                if (bus.go) begin
                    w_nextState = S_LOAD;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Run status and watchdog. LOAD starts every run from a clean slate;
    // DONE and IDLE simply hold whatever the last run left behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iterCount <= '0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_iterCount <= '0;
                    r_timeout   <= 1'b0;
                    r_wdog      <= '0;
                end
                S_CLR: begin
                    r_wdog <= '0;
                end
                S_COMPUTE: begin
                    r_wdog <= r_wdog + WDOG_W'(1);
                    if (!bus.plu_done && w_wdogExpire) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (!w_iterSat) begin
                        r_iterCount <= r_iterCount + ITER_W'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.finish) begin
                        r_timeout <= 1'b0;
                    end else if (w_capHit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode. Everything here depends on the state register
    // only, so the datapath sees glitch-free, cycle-aligned controls.
    always_comb begin
        w_rstPlu   = 1'b0;
        w_epsRegWe = 1'b0;
        w_weAReg   = 1'b0;
        w_wePrim   = 1'b0;
        w_muxSel   = 1'b0;
        w_start    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_epsRegWe = 1'b1;
                w_weAReg   = 1'b1;
                w_wePrim   = 1'b1;
                w_busy     = 1'b1;
            end
            S_CLR: begin
                w_rstPlu = 1'b1;
                w_muxSel = 1'b1;
                w_busy   = 1'b1;
            end
            S_COMPUTE: begin
                w_start  = 1'b1;
                w_muxSel = 1'b1;
                w_busy   = 1'b1;
            end
            S_UPDATE: begin
                w_weAReg = 1'b1;
                w_muxSel = 1'b1;
                w_busy   = 1'b1;
            end
            S_CHECK: begin
                w_muxSel = 1'b1;
                w_busy   = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.rst_plu    = w_rstPlu;
    assign bus.eps_reg_we = w_epsRegWe;
    assign bus.we_a_reg   = w_weAReg;
    assign bus.we_prim    = w_wePrim;
    assign bus.mux_sel    = w_muxSel;
    assign bus.start      = w_start;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.timeout    = r_timeout;
    assign bus.iter_count = r_iterCount;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxnet_ctrl
// Directed bench for maxnet_ctrl with MAX_ITER=4, WDOG=8. A small datapath
// model answers start with plu_done after a programmable latency and raises
// finish in a chosen CHECK cycle. Each run pushes its expected result into
// a scoreboard queue; an independent monitor pops and compares whenever the
// controller raises done. An optional control-word trace queue is compared
// cycle by cycle by the same monitor.
// ---------------------------------------------------------------------------
module tb_maxnet_ctrl;

    localparam int MAX_ITER = 4;
    localparam int ITER_W   = 7;
    localparam int WDOG     = 8;

    // Control word layout: {rst_plu, eps_reg_we, we_a_reg, we_prim,
    //                       mux_sel, start, busy, done}
    localparam logic [7:0] W_IDLE    = 8'b0000_0000;
    localparam logic [7:0] W_LOAD    = 8'b0111_0010;
    localparam logic [7:0] W_CLR     = 8'b1000_1010;
    localparam logic [7:0] W_COMPUTE = 8'b0000_1110;
    localparam logic [7:0] W_UPDATE  = 8'b0010_1010;
    localparam logic [7:0] W_CHECK   = 8'b0000_1010;
    localparam logic [7:0] W_DONE    = 8'b0000_0001;

    typedef struct {
        logic timeout;
        int   iterCount;
        int   weaPulses;
        int   startCycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks = 0;
    int   errors = 0;

    exp_t       expQ[$];
    logic [7:0] traceQ[$];

    // Datapath model knobs, set by the stimulus before each run.
    int   pluLatency = 1;
    logic pluEnable  = 1'b1;
    int   finishAt   = 0;
    int   startRun   = 0;
    int   checkSeen  = 0;
    logic inCheck;

    always #5 clk = ~clk;

    maxnet_ctrl_if #(.ITER_W(ITER_W)) bus();

    maxnet_ctrl #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W),
        .WDOG     (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] ctrlWord();
        return {bus.rst_plu, bus.eps_reg_we, bus.we_a_reg, bus.we_prim,
                bus.mux_sel, bus.start, bus.busy, bus.done};
    endfunction

    // Datapath response: plu_done after pluLatency cycles of start, finish
    // in the finishAt-th CHECK of the run (0 = never).
    always_comb begin
        inCheck      = bus.busy && bus.mux_sel && !bus.start && !bus.we_a_reg && !bus.rst_plu;
        bus.plu_done = bus.start && pluEnable && ((startRun + 1) >= pluLatency);
        bus.finish   = inCheck && (finishAt != 0) && ((checkSeen + 1) == finishAt);
    end

    // Datapath model history: length of the current start burst and number
    // of CHECK cycles seen since the last LOAD.
    always @(posedge clk) begin
        startRun <= bus.start ? startRun + 1 : 0;
        if (bus.we_prim) begin
            checkSeen <= 0;
        end else if (inCheck) begin
            checkSeen <= checkSeen + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: per-cycle trace compare, exclusivity of busy/done, LOAD-only
    // epsilon write, and scoreboard pop on every rising edge of done.
    initial begin
        int         weaCnt;
        int         startCnt;
        logic       prevDone;
        exp_t       e;
        logic [7:0] w;
        weaCnt   = 0;
        startCnt = 0;
        prevDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            w = ctrlWord();
            if (traceQ.size() > 0) begin
                checkOutput("trace", {24'd0, w}, {24'd0, traceQ.pop_front()});
            end
            checkOutput("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
            checkOutput("eps_only_in_load", {31'd0, bus.eps_reg_we}, {31'd0, bus.we_prim});
            if (bus.we_prim) begin
                weaCnt   = 0;
                startCnt = 0;
            end else begin
                if (bus.we_a_reg) weaCnt++;
                if (bus.start)    startCnt++;
            end
            if (bus.done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no result pending");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result_timeout", {31'd0, bus.timeout}, {31'd0, e.timeout});
                    checkOutput("result_iter", {25'd0, bus.iter_count}, e.iterCount);
                    checkOutput("result_wea_pulses", weaCnt, e.weaPulses);
                    checkOutput("result_start_cycles", startCnt, e.startCycles);
                end
            end
            prevDone = bus.done;
        end
    end

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_done_wait: got no done within 300 cycles, expected done", name);
        end
        @(negedge clk);
    endtask

    // One complete run: configure the model, queue the expected result,
    // pulse go, confirm LOAD then cleared status in CLR, wait for done.
    task automatic applyStimulus(input string name, input int k, input logic en, input int fin,
                                 input logic expTo, input int expIter, input int expWea,
                                 input int expStart, input logic withTrace);
        exp_t e;
        @(negedge clk);
        pluLatency    = k;
        pluEnable     = en;
        finishAt      = fin;
        e.timeout     = expTo;
        e.iterCount   = expIter;
        e.weaPulses   = expWea;
        e.startCycles = expStart;
        expQ.push_back(e);
        if (withTrace) begin
            traceQ.push_back(W_LOAD);
            traceQ.push_back(W_CLR);
            traceQ.push_back(W_COMPUTE);
            traceQ.push_back(W_COMPUTE);
            traceQ.push_back(W_UPDATE);
            traceQ.push_back(W_CHECK);
            traceQ.push_back(W_DONE);
        end
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, "_load"}, {31'd0, bus.we_prim}, 32'd1);
        @(negedge clk);
        bus.go = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "_clr_iter"}, {25'd0, bus.iter_count}, 32'd0);
        checkOutput({name, "_clr_timeout"}, {31'd0, bus.timeout}, 32'd0);
        waitDone(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        exp_t e;
        int   n;
        bus.go = 1'b1;
        rst    = 1'b1;

        // Reset held three cycles with go high: controller stays idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_ctrl", {24'd0, ctrlWord()}, {24'd0, W_IDLE});
            checkOutput("reset_iter", {25'd0, bus.iter_count}, 32'd0);
            checkOutput("reset_timeout", {31'd0, bus.timeout}, 32'd0);
        end
        pluLatency    = 1;
        pluEnable     = 1'b1;
        finishAt      = 1;
        e.timeout     = 1'b0;
        e.iterCount   = 1;
        e.weaPulses   = 1;
        e.startCycles = 1;
        expQ.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_load", {24'd0, ctrlWord()}, {24'd0, W_LOAD});
        @(negedge clk);
        bus.go = 1'b0;
        waitDone("after_reset");

        // Converge after one iteration, plu_done two cycles into COMPUTE.
        applyStimulus("converge1", 2, 1'b1, 1, 1'b0, 1, 1, 2, 1'b1);
        // Never finishes: iteration cap aborts after 4 write-backs.
        applyStimulus("cap_abort", 1, 1'b1, 0, 1'b1, 4, 4, 4, 1'b0);
        // plu_done never returns: watchdog aborts after 8 start cycles.
        applyStimulus("wdog_abort", 1, 1'b0, 0, 1'b1, 0, 0, 8, 1'b0);
        // finish in the same CHECK where the cap is reached: converged.
        applyStimulus("finish_vs_cap", 1, 1'b1, 4, 1'b0, 4, 4, 4, 1'b0);

        // Reset during COMPUTE of the second iteration.
        @(negedge clk);
        pluLatency = 3;
        pluEnable  = 1'b1;
        finishAt   = 0;
        bus.go     = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        n = 0;
        while (!(bus.start === 1'b1 && bus.iter_count == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_run_reached", {31'd0, bus.start}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_ctrl", {24'd0, ctrlWord()}, {24'd0, W_IDLE});
        checkOutput("mid_rst_iter", {25'd0, bus.iter_count}, 32'd0);
        checkOutput("mid_rst_timeout", {31'd0, bus.timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", {24'd0, ctrlWord()}, {24'd0, W_IDLE});

        // Fresh run from IDLE after the reset, converging on the 2nd CHECK.
        applyStimulus("restart", 1, 1'b1, 2, 1'b0, 2, 2, 2, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        checkOutput("trace_drained", traceQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
